// File: rtl/tile_cfg_bank_loader.sv
// Configuration loader for a tile column's memory banks. It assembles one full
// bit-line row from a stream of configuration words, holds it stable, strobes
// that row's word line, and repeats for every word-line row of the column.
//
// Handshake: a word moves on a rising edge where cfg_valid && cfg_ready are
// both high. cfg_valid may rise or fall at any time. cfg_data must be stable
// whenever cfg_valid is high. cfg_ready is high only while a row is being
// assembled, and it does not depend combinationally on cfg_valid.
//
// SETUP_CYC and WL_PULSE must both be at least 1.
module tile_cfg_bank_loader #(
    parameter int BL_WIDTH  = 315,
    parameter int WL_WIDTH  = 4,
    parameter int DIN_WIDTH = 32,
    parameter int SETUP_CYC = 1,
    parameter int WL_PULSE  = 2,
    localparam int RW       = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIN_WIDTH-1:0] cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [BL_WIDTH-1:0]  bl_out,
    output logic [WL_WIDTH-1:0]  wl_out,
    output logic [RW-1:0]        row_idx,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_dbg
);

    // Words needed to fill one bit-line row; the last word may be partly unused.
    localparam int WPR  = (BL_WIDTH + DIN_WIDTH - 1) / DIN_WIDTH;
    localparam int WCW  = (WPR > 1) ? $clog2(WPR) : 1;
    // The phase timer serves both SETUP and PULSE, so it is sized for the longer one.
    localparam int TMAX = (SETUP_CYC > WL_PULSE) ? SETUP_CYC : WL_PULSE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state;
    logic [WCW-1:0] word_cnt;
    logic [TW-1:0]  tmr;

    assign state_dbg = state;

    // Sequence controller. All outputs are registered and change on the same
    // edge as the state, so they always agree with the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bl_out    <= '0;
            wl_out    <= '0;
            row_idx   <= '0;
            word_cnt  <= '0;
            tmr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_LOAD;
                        row_idx   <= '0;
                        word_cnt  <= '0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (cfg_valid && cfg_ready) begin
                        // Beat k covers bit-line bits [k*DIN_WIDTH +: DIN_WIDTH].
                        // Bits past BL_WIDTH have no target, so they are dropped.
                        for (int i = 0; i < BL_WIDTH; i++) begin
                            if (word_cnt == WCW'(i / DIN_WIDTH)) begin
                                bl_out[i] <= cfg_data[i % DIN_WIDTH];
                            end
                        end
                        if (word_cnt == WCW'(WPR - 1)) begin
                            word_cnt  <= '0;
                            cfg_ready <= 1'b0;
                            tmr       <= '0;
                            state     <= S_SETUP;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end

                S_SETUP: begin
                    // Bit lines settle for SETUP_CYC cycles before the word line rises.
                    if (tmr == TW'(SETUP_CYC - 1)) begin
                        tmr    <= '0;
                        wl_out <= WL_WIDTH'(1) << row_idx;
                        state  <= S_PULSE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                S_PULSE: begin
                    if (tmr == TW'(WL_PULSE - 1)) begin
                        tmr    <= '0;
                        wl_out <= '0;
                        state  <= S_HOLD;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                S_HOLD: begin
                    // One quiet cycle after the word line falls, before bit lines may move.
                    if (row_idx == RW'(WL_WIDTH - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        row_idx   <= row_idx + 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= S_LOAD;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state     <= S_IDLE;
                    wl_out    <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    // Word lines are never multi-hot.
    a_wl_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(wl_out));

    // The loader accepts words only while a row is being assembled.
    a_ready_in_load: assert property (@(posedge clk) disable iff (!reset)
        cfg_ready |-> (state == S_LOAD));

    // A word line is active only during the pulse phase, never while bit lines can move.
    a_wl_in_pulse: assert property (@(posedge clk) disable iff (!reset)
        (wl_out != '0) |-> (state == S_PULSE));

endmodule

// File: tb/tb_tile_cfg_bank_loader.sv
// Directed bench for tile_cfg_bank_loader. The main instance uses the default
// parameters. A second instance covers a small single-row configuration with a
// single full-width word per row.
module tb_tile_cfg_bank_loader;

    localparam int BLW = 315;
    localparam int WLW = 4;
    localparam int DW  = 32;
    localparam int WPR = 10;
    localparam int NW  = WLW * WPR;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           start;
    logic [DW-1:0]  cfg_data;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [BLW-1:0] bl_out;
    logic [WLW-1:0] wl_out;
    logic [1:0]     row_idx;
    logic           busy;
    logic           done;
    logic [2:0]     state_dbg;

    logic           start2;
    logic [63:0]    cfg_data2;
    logic           cfg_valid2;
    logic           cfg_ready2;
    logic [63:0]    bl_out2;
    logic [0:0]     wl_out2;
    logic [0:0]     row_idx2;
    logic           busy2;
    logic           done2;
    logic [2:0]     state_dbg2;

    tile_cfg_bank_loader dut (
        .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .bl_out(bl_out),
        .wl_out(wl_out), .row_idx(row_idx), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    tile_cfg_bank_loader #(
        .BL_WIDTH(64), .WL_WIDTH(1), .DIN_WIDTH(64), .SETUP_CYC(3), .WL_PULSE(1)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cfg_data(cfg_data2),
        .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2), .bl_out(bl_out2),
        .wl_out(wl_out2), .row_idx(row_idx2), .busy(busy2), .done(done2),
        .state_dbg(state_dbg2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Word stream for the current pass: row r uses words[r*WPR .. r*WPR+WPR-1].
    logic [DW-1:0] words [NW];

    // Expected bit-line row, built directly from the beat-to-bit mapping.
    function automatic logic [BLW-1:0] exp_row(input int r);
        logic [BLW-1:0] v;
        v = '0;
        for (int k = 0; k < WPR; k++) begin
            for (int j = 0; j < DW; j++) begin
                if (k * DW + j < BLW) v[k*DW+j] = words[r*WPR+k][j];
            end
        end
        return v;
    endfunction

    // ---------------- driver / monitor for one full pass ----------------
    // start_mode: 0 = single start pulse, 1 = extra start pulses while busy,
    // 2 = start held high. Returns at the falling edge inside the done cycle.
    task automatic run_pass(input int stall_pct, input int start_mode);
        int c         = 0;
        int widx      = 0;
        int busy_cnt  = 0;
        int idle_cnt  = 0;
        int pulse_cnt = 0;
        int r;
        bit seen_done = 1'b0;
        logic [BLW-1:0] ev;
        logic [WLW-1:0] ew;
        @(negedge clk);
        start     = 1'b1;
        cfg_valid = 1'b0;
        while (!seen_done && c < 3000) begin
            @(negedge clk);
            c++;
            if (start_mode == 0)      start = 1'b0;
            else if (start_mode == 1) start = (c % 5 == 0);
            else                      start = 1'b1;
            if (busy) busy_cnt++;
            if (wl_out != '0) begin
                r = pulse_cnt / 2;
                if (r > WLW - 1) r = WLW - 1;
                ev = exp_row(r);
                ew = 4'b0001 << r;
                n_cmp++;
                if (wl_out !== ew) begin
                    n_fail++;
                    $display("FAIL wl_seq: pulse %0d wl_out=%b expected %b", pulse_cnt, wl_out, ew);
                end
                n_cmp++;
                if (row_idx !== r[1:0]) begin
                    n_fail++;
                    $display("FAIL row_idx_pulse: got %0d expected %0d", row_idx, r);
                end
                n_cmp++;
                if (bl_out !== ev) begin
                    n_fail++;
                    $display("FAIL bl_row%0d: got %h expected %h", r, bl_out, ev);
                end
                if (pulse_cnt == 0) begin
                    n_cmp++;
                    if (bl_out[31:0] !== words[0]) begin
                        n_fail++;
                        $display("FAIL row0_word0: got %h expected %h", bl_out[31:0], words[0]);
                    end
                    n_cmp++;
                    if (bl_out[314:288] !== words[9][26:0]) begin
                        n_fail++;
                        $display("FAIL row0_last: got %h expected %h", bl_out[314:288], words[9][26:0]);
                    end
                end
                pulse_cnt++;
            end
            if (cfg_ready) begin
                n_cmp++;
                if (wl_out !== '0) begin
                    n_fail++;
                    $display("FAIL wl_in_load: cycle %0d wl_out=%b expected 0", c, wl_out);
                end
            end
            if (done) seen_done = 1'b1;
            if (cfg_ready && widx < NW && !seen_done) begin
                cfg_valid = ($urandom_range(0, 99) >= stall_pct);
                cfg_data  = words[widx];
                if (cfg_valid) widx++;
                else idle_cnt++;
            end else begin
                cfg_valid = 1'b0;
                cfg_data  = '0;
            end
        end
        n_cmp++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", c);
        end
        n_cmp++;
        if (busy_cnt !== 56 + idle_cnt) begin
            n_fail++;
            $display("FAIL busy_len: got %0d expected %0d", busy_cnt, 56 + idle_cnt);
        end
        n_cmp++;
        if (c !== 57 + idle_cnt) begin
            n_fail++;
            $display("FAIL done_cycle: got %0d expected %0d", c, 57 + idle_cnt);
        end
        n_cmp++;
        if (pulse_cnt !== 8) begin
            n_fail++;
            $display("FAIL pulse_cycles: got %0d expected 8", pulse_cnt);
        end
        n_cmp++;
        if (widx !== NW) begin
            n_fail++;
            $display("FAIL beats: got %0d expected %0d", widx, NW);
        end
        if (start_mode != 2) begin
            start = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL after_done: done=%b busy=%b expected 0 0", done, busy);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        $display("info: state codes in reset = %0d %0d", state_dbg, state_dbg2);
        n_cmp++;
        if (bl_out !== '0) begin n_fail++; $display("FAIL rst_bl: got %h expected 0", bl_out); end
        n_cmp++;
        if (wl_out !== '0) begin n_fail++; $display("FAIL rst_wl: got %b expected 0", wl_out); end
        n_cmp++;
        if (row_idx !== '0) begin n_fail++; $display("FAIL rst_row: got %0d expected 0", row_idx); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", cfg_ready); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy=%b ready=%b expected 0 0", busy, cfg_ready);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
        run_pass(0, 0);
    endtask

    task automatic test_stalls();
        for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
        run_pass(50, 0);
    endtask

    task automatic test_last_word();
        for (int i = 0; i < NW; i++) words[i] = 32'hA500_0000 | 32'(i);
        words[29] = 32'hFFFF_FFFF;
        run_pass(0, 0);
    endtask

    task automatic test_reset_mid_pass();
        int widx = 0;
        int c    = 0;
        for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
        @(negedge clk);
        start = 1'b1;
        while (wl_out !== 4'b0010 && c < 200) begin
            @(negedge clk);
            c++;
            start     = 1'b0;
            cfg_valid = cfg_ready;
            cfg_data  = words[widx % NW];
            if (cfg_ready) widx++;
        end
        n_cmp++;
        if (wl_out !== 4'b0010) begin
            n_fail++;
            $display("FAIL row1_pulse_timeout: wl_out=%b expected 0010", wl_out);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (bl_out !== '0 || wl_out !== '0 || row_idx !== '0) begin
            n_fail++;
            $display("FAIL async_rst_bus: bl=%h wl=%b row=%0d expected all 0", bl_out, wl_out, row_idx);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_ctl: busy=%b done=%b ready=%b expected 0 0 0", busy, done, cfg_ready);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NW; i++) words[i] = 32'(i * 3 + 7) ^ 32'h5A5A_0000;
        run_pass(0, 0);
    endtask

    task automatic test_start_pokes();
        for (int i = 0; i < NW; i++) words[i] = ~32'(i);
        run_pass(0, 1);
    endtask

    task automatic test_start_held();
        for (int i = 0; i < NW; i++) words[i] = 32'(i) << 3;
        run_pass(0, 2);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL held_idle: busy=%b done=%b ready=%b expected 0 0 0", busy, done, cfg_ready);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1 || row_idx !== 2'd0 || wl_out !== '0) begin
            n_fail++;
            $display("FAIL held_restart: busy=%b ready=%b row=%0d wl=%b expected 1 1 0 0",
                     busy, cfg_ready, row_idx, wl_out);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [63:0] d = 64'hDEAD_BEEF_0123_4567;
        logic e_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic e_done [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic e_wl   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic e_rdy  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        start2     = 1'b1;
        cfg_valid2 = 1'b1;
        cfg_data2  = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (c >= 1) cfg_valid2 = 1'b0;
            n_cmp++;
            if (busy2 !== e_busy[c] || done2 !== e_done[c] || wl_out2[0] !== e_wl[c] ||
                cfg_ready2 !== e_rdy[c] || row_idx2 !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_ctl: cycle %0d busy=%b done=%b wl=%b ready=%b row=%0d expected %b %b %b %b 0",
                         c + 1, busy2, done2, wl_out2, cfg_ready2, row_idx2,
                         e_busy[c], e_done[c], e_wl[c], e_rdy[c]);
            end
            if (c >= 1) begin
                n_cmp++;
                if (bl_out2 !== d) begin
                    n_fail++;
                    $display("FAIL sweep_bl: cycle %0d got %h expected %h", c + 1, bl_out2, d);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        cfg_data   = '0;
        cfg_valid  = 1'b0;
        start2     = 1'b0;
        cfg_data2  = '0;
        cfg_valid2 = 1'b0;
        test_reset();
        test_basic();
        test_stalls();
        test_last_word();
        test_reset_mid_pass();
        test_start_pokes();
        test_start_held();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_cfg_bank_loader.md
Name: tile_cfg_bank_loader

Overview:
- Memory-bank configuration driver that sits directly upstream of the tile chain.
- Drives the bl_in/wl_in buses of the first tile, which passes them through to later tiles.
- Accepts a configuration word stream with a valid/ready handshake and assembles one full bit-line row.
- Then strobes the matching word line, and repeats for every word-line row of the tile column.

Parameters:
- BL_WIDTH, 315, bit-line bus width; matches the tile bl_in.
- WL_WIDTH, 4, word-line count; matches the tile wl_in.
- DIN_WIDTH, 32, width of one configuration input word.
- SETUP_CYC, 1, cycles BL is held stable before the WL pulse; must be ≥1.
- WL_PULSE, 2, width of the WL pulse in cycles; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a full configuration pass.
- cfg_data  input  DIN_WIDTH  configuration word.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- bl_out  output  BL_WIDTH  bit-line bus to tile bl_in.
- wl_out  output  WL_WIDTH  one-hot word-line bus to tile wl_in.
- row_idx  output  clog2(WL_WIDTH)  row currently being loaded or written.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse when the pass completes.

Behaviour:
- Derived constant: WPR = ceil(BL_WIDTH/DIN_WIDTH), words per row; 10 at defaults.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - bl_out, wl_out, row_idx, word counter, busy, done, cfg_ready all 0.
  - Applies immediately, including mid-pass; any partial row is discarded.
- All other transitions are on the rising edge of clk.
- IDLE:
  - cfg_ready=0, busy=0.
  - start=1 → LOAD with row_idx=0 and word counter=0.
  - start in any other state is ignored.
- LOAD:
  - cfg_ready=1, busy=1, wl_out=0.
  - Beat accepted when cfg_valid&cfg_ready. Beat k (0-based) writes bl_out[k*DIN_WIDTH+j] = cfg_data[j] for every j with k*DIN_WIDTH+j < BL_WIDTH.
  - Excess high bits of the last beat are dropped.
  - Unaccepted cycles hold all state; the stall length is unbounded.
  - bl_out bits not yet overwritten keep the previous row's values. This is harmless because WL stays low.
  - On the WPR-th beat → SETUP, with the counter cleared and cfg_ready=0 from the next cycle.
- SETUP:
  - Lasts SETUP_CYC cycles, wl_out=0, bl_out frozen, then → PULSE.
- PULSE:
  - Lasts WL_PULSE cycles, wl_out = 1<<row_idx, bl_out frozen, then → HOLD.
- HOLD:
  - Lasts 1 cycle, wl_out=0, bl_out frozen.
  - If row_idx==WL_WIDTH-1 → DONE. Otherwise row_idx+1 → LOAD.
- DONE:
  - Lasts 1 cycle, done=1, busy=0, then → IDLE.
  - bl_out keeps the last row's data until the next pass or reset.
- Invariants:
  - wl_out is never multi-hot.
  - wl_out is never nonzero while bl_out can change (LOAD) or in the cycle adjacent to a bl_out change.
  - cfg_ready is high only in LOAD.
- Timing with no stalls: pass length = WL_WIDTH*(WPR+SETUP_CYC+WL_PULSE+1) busy cycles, followed by the done cycle.
  - Defaults: 56 busy cycles; done is high in cycle 57 after the start edge.
- Counters use exact widths; row_idx never exceeds WL_WIDTH-1.

Test Plan:
- Defaults, reset released, start, cfg_valid always 1, words 0x0000_0001..0x0000_0028.
  - busy for 56 cycles; done pulses once in cycle 57.
  - wl_out sequence: 0001, 0010, 0100, 1000, each for 2 cycles.
  - Row 0 bl_out[31:0]=1, bl_out[288+26:288] = low 27 bits of 0x0A.
- Random cfg_valid gaps (≥30% idle) in every row.
  - Same final bl_out/wl_out trace as the stall-free run, only stretched in time.
  - wl_out stays 0 during every LOAD cycle.
- Last word of row 2 = 0xFFFF_FFFF.
  - Only bl_out[314:288] set from that word; no out-of-range writes.
  - wl_out[2] pulses with bl_out[314:288] all ones.
- Assert reset=0 during row 1 PULSE.
  - All outputs 0 asynchronously (before the next clk edge).
  - A new start after release begins again at row 0 with a full WPR beats.
- start pulses while busy, and start held high across DONE.
  - Mid-pass starts are ignored.
  - Held start re-triggers a pass only from IDLE, one cycle after DONE.
- Parameter sweep: BL_WIDTH=64, DIN_WIDTH=64, WL_WIDTH=1, SETUP_CYC=3, WL_PULSE=1.
  - 1 beat, then 3 setup cycles, 1 pulse cycle on wl_out[0], 1 hold cycle.
  - done is high in the cycle after the hold.
